prpg_word_packer: RTL and testbench
===================================

// Module: prpg_word_packer
// PURPOSE
//  Downstream stage of the N-bit PRPG. Packs its serial output bit, one bit per enabled cycle, into N-bit words.
//  Buffers the words in a small FIFO and hands them out with a valid/ready handshake.
//  Also latches the per-window ones count (num/valid) and tracks its running minimum and maximum for BIST reporting.
// PARAMETERS
//  N      4  word width; equals the PRPG width (4/8/16/32)
//  DEPTH  4  FIFO entries; power of 2, >=2
//  AW     $clog2(DEPTH)  derived; not overridable
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  load       in   1      sync restart, aligned with PRPG load; clears packer, FIFO, stats and flags
//  seq_bit    in   1      PRPG serial output bit
//  seq_en     in   1      seq_bit is valid this cycle
//  num_in     in   N      PRPG ones count for the last window
//  num_valid  in   1      num_in valid, 1-cycle pulse
//  word_out   out  N      FIFO head word
//  out_valid  out  1      FIFO not empty
//  out_ready  in   1      consumer accepts; pop when out_valid&&out_ready
//  fill       out  AW+1   FIFO occupancy, 0..DEPTH
//  min_ones   out  N      minimum num_in seen since reset/load
//  max_ones   out  N      maximum num_in seen since reset/load
//  overflow   out  1      sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (reset_n=0, async): all state 0; word_out=0, out_valid=0, fill=0, max_ones=0, min_ones={N{1}}, overflow=0.
//  load=1 (sync): same values as reset. All other inputs are ignored that cycle, and no pop occurs.
//  Packer FSM
//   EMPTY: no bits held. seq_en -> shreg[0]=seq_bit, bit_cnt=1, go to FILL.
//   FILL: seq_en -> shreg[bit_cnt]=seq_bit, bit_cnt++. The first bit received is the word LSB.
//    When the Nth bit arrives, the word {seq_bit,shreg[N-2:0]} is pushed that same edge, bit_cnt=0, go to EMPTY.
//   seq_en=0 holds the state. The packer never stalls; bits keep arriving regardless of FIFO state.
//  FIFO
//   Push-to-out_valid latency is 1 cycle (the word is visible the cycle after the Nth bit's edge).
//   word_out = mem[rd_ptr], read combinationally. It is held stable while out_valid&&!out_ready.
//   Push and pop in the same cycle: both happen and fill is unchanged. This holds when full, so full+pop+push does not drop.
//   Full and push without pop: the word is dropped, overflow<=1, and fill, pointers and contents are unchanged.
//   Empty with out_ready: no effect.
//   Pointers are AW bits and wrap modulo DEPTH. fill is a separate counter.
//  Stats: on num_valid, max_ones<=max(max_ones,num_in) and min_ones<=min(min_ones,num_in). Comparisons are unsigned, N bits.
//  A num_valid pulse and the Nth bit in the same cycle are both processed independently.
//  reset_n asserted mid-word discards any partial word. No partial-word flush exists.
// CONFIGURATION
//  PRPG_PACK_PARITY_EN defined:
//   Adds output word_par (1 bit) = ^word_out, i.e. even parity of the head word.
//   The FIFO stores N+1 bits per entry, with parity computed at push.
//  Not defined: word_par is absent, the FIFO stores N bits, and all else is identical.
// STRUCTURE
//  Shared package prpg_pkg holds:
//   localparam PRPG_W_DEFAULT=4
//   state enum PACK_EMPTY=1'b0, PACK_FILL=1'b1
//   function clog2 helper
//  One sub-module: prpg_sync_fifo #(W,DEPTH)
//   Ports: clk, reset_n, clr, push, din, pop, dout, empty, full, fill.
//   prpg_word_packer owns the FSM, overflow and stats logic.
// TESTING (N=4, DEPTH=4)
//  Reset: hold reset_n=0 -> out_valid=0, fill=0, min_ones=4'hF, max_ones=0, overflow=0. Release -> outputs unchanged.
//  Pack: seq_en=1 with bits 1,0,1,1 on 4 consecutive cycles -> next cycle out_valid=1, word_out=4'b1101, fill=1.
//  Gapped input: same 4 bits with seq_en=0 gaps in between -> same word_out=4'b1101, and no push before the 4th bit.
//  Overflow: out_ready=0, 5 words pushed -> fill=4, overflow=1, first 4 words retained.
//   Then out_ready=1 -> words drain in order and fill returns to 0.
//  Simultaneous: FIFO full, out_ready=1 on the cycle a 4th bit arrives -> fill stays 4, overflow stays 0.
//  Stats/load: num_valid with num_in=3, 7, 2 -> min_ones=2, max_ones=7.
//   Then load=1 for one cycle -> min_ones=4'hF, max_ones=0, fill=0, overflow=0, and a partial word is discarded.

Source files
------------

// File: rtl/prpg_pkg.sv
// Shared definitions for the PRPG word packer slice: default width, packer
// state encoding and a constant-evaluable ceil(log2) helper.
package prpg_pkg;

    localparam int PRPG_W_DEFAULT = 4;

    typedef enum logic {
        PACK_EMPTY = 1'b0,
        PACK_FILL  = 1'b1
    } pack_state_t;

    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/prpg_sync_fifo.sv
// Synchronous FIFO with combinational head read, separate occupancy counter
// and a synchronous clear. A push while full is accepted only if a pop frees a slot.
module prpg_sync_fifo
    import prpg_pkg::*;
#(
    parameter  int W     = 4,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   fill
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop_eff;
    logic          push_eff;

    assign empty    = (fill == '0);
    assign full     = (fill == (AW+1)'(DEPTH));
    assign dout     = mem[rd_ptr];
    assign pop_eff  = pop && !empty;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign push_eff = push && (!full || pop_eff);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_eff) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_eff && !pop_eff) begin
                fill <= fill + (AW+1)'(1);
            end else if (pop_eff && !push_eff) begin
                fill <= fill - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/prpg_word_packer.sv
// Packs the PRPG serial bit stream (LSB first) into N-bit words, queues them in a
// FIFO with valid/ready output, and tracks min/max ones counts. Optional macro
// PRPG_PACK_PARITY_EN adds a word_par output carried through the FIFO.
module prpg_word_packer
    import prpg_pkg::*;
#(
    parameter  int N     = PRPG_W_DEFAULT,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          seq_bit,
    input  logic          seq_en,
    input  logic [N-1:0]  num_in,
    input  logic          num_valid,
    output logic [N-1:0]  word_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   fill,
`ifdef PRPG_PACK_PARITY_EN
    output logic          word_par,
`endif
    output logic [N-1:0]  min_ones,
    output logic [N-1:0]  max_ones,
    output logic          overflow
);

    localparam int             CW       = clog2(N);
    localparam logic [CW-1:0]  LAST_BIT = CW'(N - 1);

`ifdef PRPG_PACK_PARITY_EN
    localparam int FW = N + 1;
`else
    localparam int FW = N;
`endif

    pack_state_t    state;
    pack_state_t    state_next;
    logic [N-2:0]   shreg;
    logic [CW-1:0]  bit_cnt;
    logic           last_bit;
    logic           word_push;
    logic [N-1:0]   word_new;
    logic [FW-1:0]  fifo_din;
    logic [FW-1:0]  fifo_dout;
    logic           fifo_empty;
    logic           fifo_full;

    assign last_bit = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PACK_EMPTY;
        end else if (load) begin
            state <= PACK_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PACK_EMPTY: if (seq_en) state_next = PACK_FILL;
            PACK_FILL:  if (seq_en && last_bit) state_next = PACK_EMPTY;
            default:    state_next = PACK_EMPTY;
        endcase
    end

    always_comb begin
        word_push = 1'b0;
        word_new  = {seq_bit, shreg};
        if (state == PACK_FILL && seq_en && last_bit) begin
            word_push = 1'b1;
        end
    end

    // bit_cnt is 0 whenever the packer is EMPTY, so the same write path covers both states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (seq_en) begin
            if (state == PACK_FILL && last_bit) begin
                bit_cnt <= '0;
            end else begin
                for (int i = 0; i < N - 1; i++) begin
                    if (bit_cnt == CW'(i)) begin
                        shreg[i] <= seq_bit;
                    end
                end
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

`ifdef PRPG_PACK_PARITY_EN
    assign fifo_din = {^word_new, word_new};
    assign word_par = fifo_dout[N];
`else
    assign fifo_din = word_new;
`endif

    prpg_sync_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (load),
        .push    (word_push),
        .din     (fifo_din),
        .pop     (out_ready),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .fill    (fill)
    );

    assign word_out  = fifo_dout[N-1:0];
    assign out_valid = !fifo_empty;

    // A non-empty full FIFO pops exactly when out_ready is high, so that alone rescues the push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (load) begin
            overflow <= 1'b0;
        end else if (word_push && fifo_full && !out_ready) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_ones <= '1;
            max_ones <= '0;
        end else if (load) begin
            min_ones <= '1;
            max_ones <= '0;
        end else if (num_valid) begin
            if (num_in > max_ones) max_ones <= num_in;
            if (num_in < min_ones) min_ones <= num_in;
        end
    end

endmodule

// File: tb/tb_prpg_word_packer.sv
// Directed testbench for prpg_word_packer (N=4, DEPTH=4) with a queue scoreboard
// of expected FIFO words; honours PRPG_PACK_PARITY_EN for the parity port.
module tb_prpg_word_packer;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load;
    logic         seq_bit;
    logic         seq_en;
    logic [N-1:0] num_in;
    logic         num_valid;
    logic [N-1:0] word_out;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   fill;
    logic [N-1:0] min_ones;
    logic [N-1:0] max_ones;
    logic         overflow;
`ifdef PRPG_PACK_PARITY_EN
    logic         word_par;
`endif

    int           vectors     = 0;
    int           miscompares = 0;
    logic [N-1:0] exp_q[$];
    logic         model_ovf;

    prpg_word_packer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .seq_bit   (seq_bit),
        .seq_en    (seq_en),
        .num_in    (num_in),
        .num_valid (num_valid),
        .word_out  (word_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill),
`ifdef PRPG_PACK_PARITY_EN
        .word_par  (word_par),
`endif
        .min_ones  (min_ones),
        .max_ones  (max_ones),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Shift a word in LSB first; optionally pop the head on the edge of the last bit.
    task automatic send_word(input logic [N-1:0] w, input int gap, input bit pop_last);
        for (int i = 0; i < N; i++) begin
            seq_bit = w[i];
            seq_en  = 1'b1;
            if (i == N - 1 && pop_last) begin
                check("simul_head", {28'd0, word_out}, {28'd0, exp_q[0]});
                out_ready = 1'b1;
            end
            tick();
            seq_en    = 1'b0;
            out_ready = 1'b0;
            if (i == N - 1) begin
                if (pop_last) void'(exp_q.pop_front());
                if (exp_q.size() < DEPTH) exp_q.push_back(w);
                else model_ovf = 1'b1;
            end else if (gap > 0) begin
                repeat (gap) tick();
                check("no_early_push", {29'd0, fill}, exp_q.size());
            end
        end
    endtask

    task automatic pop_check(input string tag);
        logic [N-1:0] e;
        e = exp_q.pop_front();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_word"}, {28'd0, word_out}, {28'd0, e});
`ifdef PRPG_PACK_PARITY_EN
        check({tag, "_par"}, {31'd0, word_par}, {31'd0, ^e});
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pulse_num(input logic [N-1:0] v);
        num_in    = v;
        num_valid = 1'b1;
        tick();
        num_valid = 1'b0;
    endtask

    task automatic do_load();
        load = 1'b1;
        tick();
        load = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        load      = 1'b0;
        seq_bit   = 1'b0;
        seq_en    = 1'b0;
        num_in    = '0;
        num_valid = 1'b0;
        out_ready = 1'b0;
        model_ovf = 1'b0;

        repeat (3) tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fill", {29'd0, fill}, 32'd0);
        check("rst_min", {28'd0, min_ones}, 32'hF);
        check("rst_max", {28'd0, max_ones}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_word", {28'd0, word_out}, 32'd0);
        reset_n = 1'b1;
        tick();
        check("rel_valid", {31'd0, out_valid}, 32'd0);
        check("rel_min", {28'd0, min_ones}, 32'hF);

        send_word(4'b1101, 0, 1'b0);
        check("pack_valid", {31'd0, out_valid}, 32'd1);
        check("pack_fill", {29'd0, fill}, 32'd1);
        pop_check("pack");

        send_word(4'b1101, 2, 1'b0);
        check("gap_fill", {29'd0, fill}, 32'd1);
        pop_check("gap");

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("empty_pop_fill", {29'd0, fill}, 32'd0);
        check("empty_pop_valid", {31'd0, out_valid}, 32'd0);

        send_word(4'h3, 0, 1'b0);
        send_word(4'hA, 1, 1'b0);
        send_word(4'h6, 0, 1'b0);
        send_word(4'hE, 0, 1'b0);
        send_word(4'h9, 0, 1'b0);
        check("ovf_fill", {29'd0, fill}, 32'd4);
        check("ovf_flag", {31'd0, overflow}, {31'd0, model_ovf});
        check("ovf_hold", {28'd0, word_out}, {28'd0, exp_q[0]});
        while (exp_q.size() > 0) pop_check("drain");
        check("drain_fill", {29'd0, fill}, 32'd0);
        check("drain_ovf_sticky", {31'd0, overflow}, 32'd1);

        do_load();
        send_word(4'h1, 0, 1'b0);
        send_word(4'h2, 0, 1'b0);
        send_word(4'h4, 0, 1'b0);
        send_word(4'h8, 0, 1'b0);
        send_word(4'h7, 0, 1'b1);
        check("simul_fill", {29'd0, fill}, 32'd4);
        check("simul_ovf", {31'd0, overflow}, 32'd0);
        while (exp_q.size() > 0) pop_check("simul_drain");

        pulse_num(4'd3);
        pulse_num(4'd7);
        pulse_num(4'd2);
        check("stat_min", {28'd0, min_ones}, 32'd2);
        check("stat_max", {28'd0, max_ones}, 32'd7);

        seq_en = 1'b1; seq_bit = 1'b1; tick();
        seq_bit = 1'b1; tick();
        seq_en = 1'b0;
        send_word(4'h5, 0, 1'b0);
        send_word(4'hC, 0, 1'b0);
        seq_en = 1'b1; seq_bit = 1'b1; tick();
        seq_en = 1'b0;
        do_load();
        check("load_min", {28'd0, min_ones}, 32'hF);
        check("load_max", {28'd0, max_ones}, 32'd0);
        check("load_fill", {29'd0, fill}, 32'd0);
        check("load_ovf", {31'd0, overflow}, 32'd0);
        send_word(4'b0110, 0, 1'b0);
        pop_check("post_load");

        seq_en = 1'b1; seq_bit = 1'b1; tick();
        seq_en = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("async_rst_fill", {29'd0, fill}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        send_word(4'b0010, 0, 1'b0);
        pop_check("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
